// File: rtl/hbm_link_credit_bridge.sv
// Credit-based bridge between a FlooNoC valid/ready port pair and the die-to-die HBM link.
// Optional perf counters are enabled by defining HBM_CREDIT_BRIDGE_PERF_EN.
module hbm_link_credit_bridge #(
   parameter int unsigned FlitWidth  = 64,
   parameter int unsigned NumCredits = 4,
   parameter int unsigned CntWidth   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 noc_tx_valid_i,
   output logic                 noc_tx_ready_o,
   input  logic [FlitWidth-1:0] noc_tx_data_i,
   output logic                 link_tx_valid_o,
   output logic [FlitWidth-1:0] link_tx_data_o,
   input  logic                 link_credit_i,
   input  logic                 link_rx_valid_i,
   input  logic [FlitWidth-1:0] link_rx_data_i,
   output logic                 link_credit_o,
   output logic                 noc_rx_valid_o,
   input  logic                 noc_rx_ready_i,
   output logic [FlitWidth-1:0] noc_rx_data_o,
   output logic [1:0]           err_o,
   output logic [CntWidth-1:0]  tx_flits_o,
   output logic [CntWidth-1:0]  rx_flits_o
);

   localparam int unsigned CredW = $clog2(NumCredits + 1);
   localparam int unsigned PtrW  = (NumCredits > 1) ? $clog2(NumCredits) : 1;
   localparam logic [CredW-1:0] CredMax = CredW'(NumCredits);
   localparam logic [PtrW-1:0]  PtrLast = PtrW'(NumCredits - 1);

   logic [CredW-1:0]     cred_q, cred_d;
   logic                 tx_valid_q;
   logic [FlitWidth-1:0] tx_data_q;
   logic                 tx_accept;
   logic                 cred_ovf;

   logic [FlitWidth-1:0] mem_q [NumCredits];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                 wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
   logic                 rx_empty, rx_full, rx_pop, rx_push, rx_ovf;
   logic                 credit_q;
   logic [1:0]           err_q;

   assign tx_accept      = noc_tx_valid_i && (cred_q != '0);
   assign noc_tx_ready_o = (cred_q != '0);

   // A credit arriving while already at the maximum is saturated and flagged.
   always_comb begin
      cred_d   = cred_q;
      cred_ovf = 1'b0;
      unique case ({tx_accept, link_credit_i})
         2'b10: cred_d = cred_q - 1'b1;
         2'b01: begin
            if (cred_q == CredMax) begin
               cred_ovf = 1'b1;
            end else begin
               cred_d = cred_q + 1'b1;
            end
         end
         default: cred_d = cred_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cred_q     <= CredMax;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         cred_q     <= cred_d;
         tx_valid_q <= tx_accept;
         if (tx_accept) begin
            tx_data_q <= noc_tx_data_i;
         end
      end
   end

   assign link_tx_valid_o = tx_valid_q;
   assign link_tx_data_o  = tx_data_q;

   assign rx_empty = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
   assign rx_full  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
   assign rx_pop   = !rx_empty && noc_rx_ready_i;
   // A pop in the same cycle frees the slot, so a write into a full FIFO is then legal.
   assign rx_push  = link_rx_valid_i && (!rx_full || rx_pop);
   assign rx_ovf   = link_rx_valid_i && rx_full && !rx_pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_wrap_d = wr_wrap_q;
      rd_ptr_d  = rd_ptr_q;
      rd_wrap_d = rd_wrap_q;
      if (rx_push) begin
         if (wr_ptr_q == PtrLast) begin
            wr_ptr_d  = '0;
            wr_wrap_d = !wr_wrap_q;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
      if (rx_pop) begin
         if (rd_ptr_q == PtrLast) begin
            rd_ptr_d  = '0;
            rd_wrap_d = !rd_wrap_q;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rx_push) begin
         mem_q[wr_ptr_q] <= link_rx_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         wr_wrap_q <= 1'b0;
         rd_ptr_q  <= '0;
         rd_wrap_q <= 1'b0;
         credit_q  <= 1'b0;
         err_q     <= 2'b00;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         wr_wrap_q <= wr_wrap_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_wrap_q <= rd_wrap_d;
         credit_q  <= rx_pop;
         err_q     <= err_q | {rx_ovf, cred_ovf};
      end
   end

   assign noc_rx_valid_o = !rx_empty;
   assign noc_rx_data_o  = mem_q[rd_ptr_q];
   assign link_credit_o  = credit_q;
   assign err_o          = err_q;

`ifdef HBM_CREDIT_BRIDGE_PERF_EN
   logic [CntWidth-1:0] tx_cnt_q, rx_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_valid_q) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end
         if (rx_push) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
         end
      end
   end

   assign tx_flits_o = tx_cnt_q;
   assign rx_flits_o = rx_cnt_q;
`else
   assign tx_flits_o = '0;
   assign rx_flits_o = '0;
`endif

endmodule

// File: tb/tb_hbm_link_credit_bridge.sv
// Directed self-checking bench for hbm_link_credit_bridge (NumCredits = 4).
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_hbm_link_credit_bridge;

   localparam int unsigned FlitWidth  = 64;
   localparam int unsigned NumCredits = 4;
   localparam int unsigned CntWidth   = 32;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic                 noc_tx_valid_i = 1'b0;
   logic                 noc_tx_ready_o;
   logic [FlitWidth-1:0] noc_tx_data_i = '0;
   logic                 link_tx_valid_o;
   logic [FlitWidth-1:0] link_tx_data_o;
   logic                 link_credit_i = 1'b0;
   logic                 link_rx_valid_i = 1'b0;
   logic [FlitWidth-1:0] link_rx_data_i = '0;
   logic                 link_credit_o;
   logic                 noc_rx_valid_o;
   logic                 noc_rx_ready_i = 1'b0;
   logic [FlitWidth-1:0] noc_rx_data_o;
   logic [1:0]           err_o;
   logic [CntWidth-1:0]  tx_flits_o;
   logic [CntWidth-1:0]  rx_flits_o;

   int testsRun    = 0;
   int testsFailed = 0;

   hbm_link_credit_bridge #(
      .FlitWidth (FlitWidth),
      .NumCredits(NumCredits),
      .CntWidth  (CntWidth)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .noc_tx_valid_i (noc_tx_valid_i),
      .noc_tx_ready_o (noc_tx_ready_o),
      .noc_tx_data_i  (noc_tx_data_i),
      .link_tx_valid_o(link_tx_valid_o),
      .link_tx_data_o (link_tx_data_o),
      .link_credit_i  (link_credit_i),
      .link_rx_valid_i(link_rx_valid_i),
      .link_rx_data_i (link_rx_data_i),
      .link_credit_o  (link_credit_o),
      .noc_rx_valid_o (noc_rx_valid_o),
      .noc_rx_ready_i (noc_rx_ready_i),
      .noc_rx_data_o  (noc_rx_data_o),
      .err_o          (err_o),
      .tx_flits_o     (tx_flits_o),
      .rx_flits_o     (rx_flits_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyReset();
      rst_i           = 1'b1;
      noc_tx_valid_i  = 1'b0;
      link_credit_i   = 1'b0;
      link_rx_valid_i = 1'b0;
      noc_rx_ready_i  = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Sends n back-to-back flits base+1..base+n, expecting credits to be available throughout.
   task automatic applyStimulus(input int n, input logic [63:0] base);
      for (int i = 1; i <= n; i++) begin
         noc_tx_valid_i = 1'b1;
         noc_tx_data_i  = base + 64'(i);
         checkOutput("tx_ready", 64'(noc_tx_ready_o), 64'd1);
         tick();
         checkOutput("tx_strobe", 64'(link_tx_valid_o), 64'd1);
         checkOutput("tx_data", link_tx_data_o, base + 64'(i));
      end
      noc_tx_valid_i = 1'b0;
   endtask

   task automatic returnCredits(input int n);
      for (int i = 0; i < n; i++) begin
         link_credit_i = 1'b1;
         tick();
      end
      link_credit_i = 1'b0;
   endtask

   task automatic writeLink(input logic [63:0] data);
      link_rx_valid_i = 1'b1;
      link_rx_data_i  = data;
      tick();
      link_rx_valid_i = 1'b0;
   endtask

   initial begin
      applyReset();
      checkOutput("rst_tx_ready", 64'(noc_tx_ready_o), 64'd1);
      checkOutput("rst_tx_valid", 64'(link_tx_valid_o), 64'd0);
      checkOutput("rst_tx_data", link_tx_data_o, 64'd0);
      checkOutput("rst_credit_o", 64'(link_credit_o), 64'd0);
      checkOutput("rst_rx_valid", 64'(noc_rx_valid_o), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);
      checkOutput("rst_tx_cnt", 64'(tx_flits_o), 64'd0);
      checkOutput("rst_rx_cnt", 64'(rx_flits_o), 64'd0);

      // Four flits drain all credits; the fifth stalls until a credit returns.
      applyStimulus(4, 64'd0);
      noc_tx_valid_i = 1'b1;
      noc_tx_data_i  = 64'd5;
      checkOutput("tx_ready_empty", 64'(noc_tx_ready_o), 64'd0);
      tick();
      checkOutput("tx_stall_strobe", 64'(link_tx_valid_o), 64'd0);
      link_credit_i = 1'b1;
      checkOutput("tx_ready_same_cycle_credit", 64'(noc_tx_ready_o), 64'd0);
      tick();
      link_credit_i = 1'b0;
      checkOutput("tx_ready_after_credit", 64'(noc_tx_ready_o), 64'd1);
      checkOutput("tx_no_strobe_yet", 64'(link_tx_valid_o), 64'd0);
      tick();
      checkOutput("tx5_strobe", 64'(link_tx_valid_o), 64'd1);
      checkOutput("tx5_data", link_tx_data_o, 64'd5);
      checkOutput("tx5_ready", 64'(noc_tx_ready_o), 64'd0);

      // cred=0, valid high and credit pulse together: accepted the next cycle.
      noc_tx_data_i = 64'd6;
      link_credit_i = 1'b1;
      checkOutput("c0_ready", 64'(noc_tx_ready_o), 64'd0);
      tick();
      link_credit_i = 1'b0;
      checkOutput("c0_strobe", 64'(link_tx_valid_o), 64'd0);
      checkOutput("c0_ready_next", 64'(noc_tx_ready_o), 64'd1);
      tick();
      noc_tx_valid_i = 1'b0;
      checkOutput("c0_tx6_strobe", 64'(link_tx_valid_o), 64'd1);
      checkOutput("c0_tx6_data", link_tx_data_o, 64'd6);
      checkOutput("c0_ready_back0", 64'(noc_tx_ready_o), 64'd0);
      tick();
      checkOutput("c0_strobe_one_cycle", 64'(link_tx_valid_o), 64'd0);

      // Restore all four credits, then one extra pulse overflows.
      returnCredits(4);
      checkOutput("ovf_err_before", 64'(err_o), 64'd0);
      returnCredits(1);
      checkOutput("ovf_err_set", 64'(err_o), 64'd1);
      applyStimulus(4, 64'h100);
      checkOutput("ovf_cred_stays4", 64'(noc_tx_ready_o), 64'd0);
      tick();
      checkOutput("ovf_err_sticky", 64'(err_o), 64'd1);

      // RX: fill the FIFO, overflow on the fifth write, then drain in order.
      applyReset();
      writeLink(64'hA1);
      checkOutput("rx_latency_valid", 64'(noc_rx_valid_o), 64'd1);
      checkOutput("rx_latency_data", noc_rx_data_o, 64'hA1);
      for (int i = 2; i <= 5; i++) begin
         writeLink(64'hA0 + 64'(i));
      end
      checkOutput("rx_ovf_err", 64'(err_o), 64'd2);
      checkOutput("rx_head_stable", noc_rx_data_o, 64'hA1);
      noc_rx_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checkOutput("rx_drain_valid", 64'(noc_rx_valid_o), 64'd1);
         checkOutput("rx_drain_data", noc_rx_data_o, 64'hA0 + 64'(i));
         checkOutput("rx_credit_pulse", 64'(link_credit_o), (i == 1) ? 64'd0 : 64'd1);
         tick();
      end
      checkOutput("rx_last_credit", 64'(link_credit_o), 64'd1);
      checkOutput("rx_empty", 64'(noc_rx_valid_o), 64'd0);
      tick();
      noc_rx_ready_i = 1'b0;
      checkOutput("rx_credit_done", 64'(link_credit_o), 64'd0);

      // Full FIFO with simultaneous write and pop: no error, new flit at the tail.
      applyReset();
      for (int i = 1; i <= 4; i++) begin
         writeLink(64'hB0 + 64'(i));
      end
      link_rx_valid_i = 1'b1;
      link_rx_data_i  = 64'hB5;
      noc_rx_ready_i  = 1'b1;
      checkOutput("fp_head", noc_rx_data_o, 64'hB1);
      tick();
      link_rx_valid_i = 1'b0;
      noc_rx_ready_i  = 1'b0;
      checkOutput("fp_no_err", 64'(err_o), 64'd0);
      checkOutput("fp_new_head", noc_rx_data_o, 64'hB2);
      checkOutput("fp_credit", 64'(link_credit_o), 64'd1);
      writeLink(64'hB6);
      checkOutput("fp_still_full", 64'(err_o), 64'd2);
      noc_rx_ready_i = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         checkOutput("fp_drain_data", noc_rx_data_o, 64'hB0 + 64'(i));
         tick();
      end
      noc_rx_ready_i = 1'b0;
      checkOutput("fp_drained", 64'(noc_rx_valid_o), 64'd0);

      // Perf counters: 10 TX and 7 RX flits.
      applyReset();
      applyStimulus(4, 64'h200);
      returnCredits(4);
      applyStimulus(4, 64'h210);
      returnCredits(4);
      applyStimulus(2, 64'h220);
      noc_rx_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         writeLink(64'h300 + 64'(i));
      end
      tick();
      tick();
      noc_rx_ready_i = 1'b0;
`ifdef HBM_CREDIT_BRIDGE_PERF_EN
      checkOutput("perf_tx", 64'(tx_flits_o), 64'd10);
      checkOutput("perf_rx", 64'(rx_flits_o), 64'd7);
`else
      checkOutput("perf_tx_off", 64'(tx_flits_o), 64'd0);
      checkOutput("perf_rx_off", 64'(rx_flits_o), 64'd0);
`endif
      checkOutput("perf_err", 64'(err_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/hbm_link_credit_bridge.md
# hbm_link_credit_bridge

- Sits on one HBM-facing FlooNoC port pair of `chiplet_soc`, between the SoC NoC and the die-to-die HBM link.
- Converts the NoC's valid/ready flit handshake into a credit-based link protocol, in both directions.
- TX: accepts flits from a `*_floo_*_o` port and forwards them while holding link credits.
- RX: buffers incoming link flits in a credit-sized FIFO, drains them into a `*_floo_*_i` port, and returns one credit per drained flit.

## Interface
Parameters:
- `FlitWidth`, 64: flit payload width in bits (instantiated with `$bits` of the floo req/rsp/wide type).
- `NumCredits`, 4: link credits, equal to the RX FIFO depth; legal range 1..16.
- `CntWidth`, 32: width of the performance counters.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `noc_tx_valid_i` input 1: NoC flit valid.
- `noc_tx_ready_o` output 1: flit accepted when valid and ready.
- `noc_tx_data_i` input FlitWidth: NoC flit.
- `link_tx_valid_o` output 1: one-cycle flit strobe on the link.
- `link_tx_data_o` output FlitWidth: link flit.
- `link_credit_i` input 1: one-cycle pulse, one credit returned by the far side.
- `link_rx_valid_i` input 1: incoming link flit strobe.
- `link_rx_data_i` input FlitWidth: incoming link flit.
- `link_credit_o` output 1: one-cycle credit-return pulse.
- `noc_rx_valid_o` output 1: flit available to the NoC.
- `noc_rx_ready_i` input 1: NoC accepts the flit.
- `noc_rx_data_o` output FlitWidth: FIFO head flit.
- `err_o` output 2: sticky; bit0 = credit overflow, bit1 = RX FIFO overflow.
- `tx_flits_o` output CntWidth: flits sent (perf).
- `rx_flits_o` output CntWidth: flits received (perf).

## Operation
- **TX credit counter** `cred`:
  - Width `$clog2(NumCredits+1)`; reset value NumCredits.
  - `noc_tx_ready_o = (cred != 0)`, purely combinational from `cred`; it does not depend on `link_credit_i`.
  - Accept (valid && ready): `cred -= 1`.
  - `link_credit_i` pulse: `cred += 1`.
  - Accept and credit pulse in the same cycle: `cred` is unchanged.
  - Credit pulse with `cred == NumCredits` and no accept in that cycle: `cred` saturates (stays NumCredits) and `err_o[0]` is set.
- **TX output register**: the accepted flit is registered; `link_tx_valid_o` is high for exactly one cycle per accepted flit. There is no backpressure on the link side.
- **RX FIFO**:
  - NumCredits entries, read and write pointers with a wrap bit.
  - Full when the pointers are equal and the wrap bits differ; empty when the pointers and wrap bits are equal.
  - `link_rx_valid_i` writes `link_rx_data_i`.
  - A write while full drops the flit, leaves the FIFO unchanged and sets `err_o[1]`.
  - A simultaneous write and pop while full is legal: the pop frees the slot in the same cycle, and no error is raised.
  - `noc_rx_valid_o = !empty`; `noc_rx_data_o` = head entry.
  - Pop on `noc_rx_valid_o && noc_rx_ready_i`.
- **Credit return**: every pop produces a `link_credit_o` pulse, registered one cycle after the pop. Back-to-back pops produce back-to-back pulses.
- `err_o` bits clear only on reset.

## Timing
- Reset values (asserted asynchronously):
  - Outputs: `link_tx_valid_o=0`, `link_tx_data_o=0`, `link_credit_o=0`, `noc_rx_valid_o=0`, `err_o=0`, both counters 0.
  - `noc_tx_ready_o=1`, because `cred=NumCredits`.
  - FIFO empty.
- TX latency: accept in cycle N gives `link_tx_valid_o` in cycle N+1. Sustained throughput is 1 flit/cycle while credits remain.
- RX latency: link write in cycle N gives `noc_rx_valid_o` in cycle N+1 if the FIFO was empty. The head flit and valid are stable until popped.
- Credit latency: pop in cycle N gives `link_credit_o` in cycle N+1.
- A returned credit is usable the cycle after its `link_credit_i` pulse.
- Reset mid-operation: all in-flight flits, FIFO contents and pending credit pulses are discarded; `cred` reloads NumCredits.

## Configuration
- `HBM_CREDIT_BRIDGE_PERF_EN` defined:
  - `tx_flits_o` increments once per `link_tx_valid_o` cycle.
  - `rx_flits_o` increments once per accepted link write; dropped overflow writes do not count.
  - Both counters wrap modulo 2^CntWidth.
- Not defined: both counter outputs are tied to 0 and no counter flops are synthesized.

## Test plan
- Reset, then 4 back-to-back TX flits 0x1..0x4 with no credits returned → 4 link strobes in cycles 1–4; `noc_tx_ready_o=0` after the 4th accept; a 5th valid stalls until one `link_credit_i` pulse, then sends the cycle after.
- `cred=0` with `noc_tx_valid_i` high and `link_credit_i` pulsing the same cycle → ready stays 0 that cycle; the flit is accepted next cycle and `cred` returns to 0.
- 4 RX link flits with `noc_rx_ready_i=0`, then a 5th → FIFO full; 5th dropped; `err_o=2'b10`; the drained order is the 4 flits in order, followed by exactly 4 `link_credit_o` pulses.
- Full FIFO, a link write and a pop in the same cycle → no error; the FIFO remains full with the new flit at the tail.
- Extra `link_credit_i` with `cred=4` → `err_o[0]=1`; `cred` stays 4.
- With the macro defined: 10 TX and 7 RX flits → `tx_flits_o=10`, `rx_flits_o=7`. Without it, both read 0.
